// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with a registered read port, occupancy count and
// sticky overflow/underflow flags. Storage contents are deliberately not reset.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [AW:0]      fifo_words,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             wr_ok;
   logic             rd_ok;

   // A full FIFO still takes a write when a read frees a slot on the same edge;
   // an empty FIFO never forwards a same-cycle write to the read port.
   always_comb begin
      wr_ok = wr_en & (~full_q | rd_en);
      rd_ok = rd_en & ~empty_q;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (rd_ok) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end

      if (wr_ok && !rd_ok) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      if (wr_en && !wr_ok) begin
         ovf_d = 1'b1;
      end
      if (rd_en && !rd_ok) begin
         unf_d = 1'b1;
      end

      full_d  = (cnt_d == CNT_FULL);
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && rst_n) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign fifo_words = cnt_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign overflow   = ovf_q;
   assign underflow  = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, watermark loop,
// random traffic against a queue model, and asynchronous reset checks.
module tb_sync_fifo;

   localparam int W = 8;
   localparam int D = 8;
   localparam int A = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         wr_en = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         rd_en = 1'b0;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic [A:0]   fifo_words;
   logic         full;
   logic         empty;
   logic         overflow;
   logic         underflow;

   always #5 clk = ~clk;

   sync_fifo #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .fifo_words(fifo_words),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   typedef struct {
      bit         wr;
      logic [7:0] data;
      bit         rd;
      int         words;
      bit         ovf;
      bit         unf;
      bit         valid;
      logic [7:0] rdata;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         n_cmp = 0;
   int         m_cnt = 0;
   bit         m_ovf = 0;
   bit         m_unf = 0;
   bit         m_valid = 0;
   logic [7:0] m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit wr, input logic [7:0] d, input bit rd, input int words,
                      input bit ovf, input bit unf, input bit valid, input logic [7:0] rdata);
      vec_t v;
      v.wr = wr; v.data = d; v.rd = rd; v.words = words;
      v.ovf = ovf; v.unf = unf; v.valid = valid; v.rdata = rdata;
      vecs.push_back(v);
   endtask

   task automatic model_reset();
      sb.delete();
      m_cnt = 0; m_ovf = 0; m_unf = 0; m_valid = 0; m_rdata = '0;
   endtask

   task automatic check_model();
      chk("words", 32'(fifo_words), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == D));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_data", 32'(rd_data), 32'(m_rdata));
   endtask

   // Called at posedge+1; drives one cycle, advances the model, checks after the edge.
   task automatic step(input bit wr, input logic [7:0] d, input bit rd);
      bit wok, rok;
      wr_en = wr; wr_data = d; rd_en = rd;
      wok = wr && (m_cnt < D || rd);
      rok = rd && (m_cnt != 0);
      if (rok) m_rdata = sb.pop_front();
      if (wok) sb.push_back(d);
      m_cnt = m_cnt + int'(wok) - int'(rok);
      if (wr && !wok) m_ovf = 1;
      if (rd && !rok) m_unf = 1;
      m_valid = rok;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
      n_vec++;
      check_model();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_words"}, 32'(fifo_words), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_valid"}, 32'(rd_valid), 0);
      chk({tag, "_rdata"}, 32'(rd_data), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_unf"}, 32'(underflow), 0);
   endtask

   // Reset is held across an edge with both requests active to show nothing is accepted.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst");
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      @(posedge clk);
      #1;
      chk("rst_hold_words", 32'(fifo_words), 0);
      chk("rst_hold_valid", 32'(rd_valid), 0);
      wr_en = 1'b0; rd_en = 1'b0;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bit filling;
      bit r_wr, r_rd;

      @(posedge clk);
      #1;
      apply_reset();

      for (int i = 1; i <= 8; i++) add(1, 8'(i), 0, i, 0, 0, 0, 8'h00);
      add(1, 8'h99, 0, 8, 1, 0, 0, 8'h00);
      for (int i = 1; i <= 8; i++) add(0, 8'h00, 1, 8 - i, 1, 0, 1, 8'(i));
      add(0, 8'h00, 1, 0, 1, 1, 0, 8'h08);
      add(1, 8'h5A, 1, 1, 1, 1, 0, 8'h08);
      for (int i = 0; i < 7; i++) add(1, 8'(8'h10 + i), 0, 2 + i, 1, 1, 0, 8'h08);
      add(1, 8'h77, 1, 8, 1, 1, 1, 8'h5A);

      foreach (vecs[i]) begin
         step(vecs[i].wr, vecs[i].data, vecs[i].rd);
         chk("tbl_words", 32'(fifo_words), 32'(vecs[i].words));
         chk("tbl_full", 32'(full), 32'(vecs[i].words == D));
         chk("tbl_empty", 32'(empty), 32'(vecs[i].words == 0));
         chk("tbl_ovf", 32'(overflow), 32'(vecs[i].ovf));
         chk("tbl_unf", 32'(underflow), 32'(vecs[i].unf));
         chk("tbl_valid", 32'(rd_valid), 32'(vecs[i].valid));
         chk("tbl_rdata", 32'(rd_data), 32'(vecs[i].rdata));
      end

      // Drain 0x10..0x16 then 0x77 across the pointer wrap.
      for (int i = 0; i < 8; i++) begin
         step(0, 8'h00, 1);
         chk("wrap_data", 32'(rd_data), (i < 7) ? 32'(8'h10 + i) : 32'h77);
      end

      apply_reset();
      filling = 1;
      for (int c = 0; c < 60; c++) begin
         if (fifo_words >= 6) filling = 0;
         else if (fifo_words <= 2) filling = 1;
         step(filling, 8'hAA, (c % 3 == 2) && !empty);
         chk("wm_words_le6", 32'(fifo_words <= 6), 1);
         if (rd_valid) chk("wm_data", 32'(rd_data), 32'hAA);
      end
      chk("wm_ovf", 32'(overflow), 0);
      chk("wm_unf", 32'(underflow), 0);

      apply_reset();
      for (int c = 0; c < 300; c++) begin
         r_wr = ($urandom_range(0, 9) < 6);
         r_rd = ($urandom_range(0, 9) < 5);
         step(r_wr, 8'($urandom), r_rd);
      end

      apply_reset();
      step(0, 8'h00, 1);
      for (int i = 0; i < 6; i++) step(1, 8'(8'hC0 + i), 0);
      step(0, 8'h00, 1);
      chk("mid_pre_words", 32'(fifo_words), 5);
      chk("mid_pre_valid", 32'(rd_valid), 1);
      chk("mid_pre_unf", 32'(underflow), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_values("midrst");
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1, 8'h3C, 0);
      step(0, 8'h00, 1);
      chk("post_rst_data", 32'(rd_data), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock byte FIFO that sits directly downstream of the write-control FSM: it accepts `wr_en`/`wr_data` from that stage, stores up to `DEPTH` words, and reports its occupancy on `fifo_words`, which the FSM uses for its high/low watermark decisions. A consumer drains it through a registered read port. Overflow and underflow attempts are rejected and recorded in sticky error flags.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 8: number of storage words. Must be a power of two, at least 2.
- `AW`, default 3: address width. Must equal log2(`DEPTH`).

- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: write request for the current cycle.
- `wr_data`, input, `WIDTH`: data to write. Sampled when `wr_en` is 1.
- `rd_en`, input, 1: read request for the current cycle.
- `rd_data`, output, `WIDTH`: registered read data.
- `rd_valid`, output, 1: 1 for exactly the cycle in which `rd_data` carries a newly popped word.
- `fifo_words`, output, `AW`+1: current occupancy, 0..`DEPTH`.
- `full`, output, 1: 1 when `fifo_words` == `DEPTH`.
- `empty`, output, 1: 1 when `fifo_words` == 0.
- `overflow`, output, 1: sticky. Set by a rejected write.
- `underflow`, output, 1: sticky. Set by a rejected read.

## Operation
- Storage: `DEPTH` x `WIDTH` register array. Contents are not reset.
- Pointers: `wr_ptr` and `rd_ptr` are each `AW` bits and wrap naturally from `DEPTH`-1 to 0. A separate `AW`+1-bit counter drives `fifo_words`.
- Write acceptance: `wr_ok` = `wr_en` & (!`full` | `rd_en`).
  - When full, a write succeeds only if it is paired with a read in the same cycle.
- Read acceptance: `rd_ok` = `rd_en` & !`empty`.
  - When empty, a read is always rejected, even if a write arrives in the same cycle. There is no fall-through.
- On `wr_ok`: `mem[wr_ptr]` <= `wr_data`, and `wr_ptr` increments.
- On `rd_ok`: `rd_data` <= `mem[rd_ptr]`, `rd_ptr` increments, and `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `rd_data` holds its value.
- Count update:
  - +1 on `wr_ok` & !`rd_ok`.
  - -1 on `rd_ok` & !`wr_ok`.
  - Unchanged when both or neither occur.
- `full` and `empty` are registered and updated on the same edge as the count, so they are always consistent with `fifo_words`.
- Error flags:
  - `overflow` <= 1 when `wr_en` & !`wr_ok`.
  - `underflow` <= 1 when `rd_en` & !`rd_ok`.
  - Both are cleared only by reset.
- A rejected operation leaves the pointers, count and memory unchanged.

## Timing
- Reset values (applied asynchronously when `rst_n` falls):
  - `wr_ptr` = 0, `rd_ptr` = 0.
  - `fifo_words` = 0, `empty` = 1, `full` = 0.
  - `rd_data` = 0, `rd_valid` = 0.
  - `overflow` = 0, `underflow` = 0.
- Reset asserted mid-operation discards all stored words immediately. No write or read is accepted while `rst_n` = 0.
- Write latency: a write accepted at edge N is reflected in `fifo_words`, `empty` and `full` after edge N. The earliest read of that word is at edge N+1, with its data on `rd_data` after that edge.
- Read latency: one cycle. `rd_en` accepted at edge N gives `rd_data`/`rd_valid` valid during the cycle after edge N.
- Back-to-back reads every cycle produce a continuous stream on `rd_valid`.
- Simultaneous write and read at `fifo_words` == `DEPTH`: both are accepted, the count stays at `DEPTH`, and `overflow` is not set.
- Simultaneous write and read at `fifo_words` == 0: only the write is accepted, the count becomes 1, and `underflow` is set.
- Wrap-around: after `DEPTH` writes, `wr_ptr` returns to 0. Data order is preserved across any number of wraps.

## Test plan
- Reset then fill: release `rst_n`, then write 0x01..0x08 on consecutive cycles. Required: `fifo_words` goes 1..8, `full` = 1 after the 8th edge, `empty` = 0, `overflow` = 0.
- Overflow: with the FIFO full, write 0x99 alone. Required: `fifo_words` stays 8, `overflow` = 1 and stays 1, and a subsequent drain returns 0x01..0x08 with no 0x99.
- Drain and underflow: read 8 times from full. Required: `rd_data` = 0x01..0x08 with `rd_valid` high on each, and `empty` = 1. A 9th read sets `underflow` = 1, leaves `rd_valid` = 0 and holds `rd_data` = 0x08.
- Simultaneous operations at the boundaries:
  - At count 0, write 0x5A and read together. Required: count becomes 1, `underflow` = 1, `rd_valid` = 0.
  - At count 8, write 0x77 and read together. Required: count stays 8, `overflow` unchanged, `rd_valid` = 1 with the oldest word.
- Watermark loop with the upstream FSM (constant data 0xAA) and a consumer reading every 3rd cycle. Required:
  - `fifo_words` never exceeds 6 and never underflows.
  - Every `rd_data` with `rd_valid` = 1 equals 0xAA.
  - `overflow` = 0 and `underflow` = 0 throughout.
- Reset mid-stream: assert `rst_n` = 0 asynchronously between edges at count 5. Required: `fifo_words` = 0, `empty` = 1, `rd_valid` = 0, and both error flags = 0 immediately, without waiting for a clock edge.
